// File: rtl/proto_sched_pkg.sv
// Shared definitions for proto_job_scheduler: protocol codes, engine bit positions,
// FSM state encoding and the protocol-to-engine select decoder.
package proto_sched_pkg;

   localparam logic [1:0] PROTO_SPI  = 2'b00;
   localparam logic [1:0] PROTO_I2C  = 2'b01;
   localparam logic [1:0] PROTO_UART = 2'b10;
   localparam logic [1:0] PROTO_ILL  = 2'b11;

   localparam int ENG_SPI  = 0;
   localparam int ENG_I2C  = 1;
   localparam int ENG_UART = 2;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LAUNCH    = 3'd1;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_RESP      = 3'd4;
   localparam logic [2:0] ST_RESP_ERR  = 3'd5;

   // The illegal code selects no engine at all.
   function automatic logic [2:0] proto_onehot(input logic [1:0] proto);
      logic [2:0] sel;
      sel = 3'b000;
      case (proto)
         PROTO_SPI:  sel[ENG_SPI]  = 1'b1;
         PROTO_I2C:  sel[ENG_I2C]  = 1'b1;
         PROTO_UART: sel[ENG_UART] = 1'b1;
         default:    sel = 3'b000;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/proto_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after ptr_i,
// wrapping at NUM_REQ, and returns it both one-hot and as an index.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IW-1:0]      idx_o
);

   logic          found;
   int            cand;
   logic [IW-1:0] cand_idx;

   always_comb begin
      grant_o  = '0;
      idx_o    = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand     = (int'(ptr_i) + i) % NUM_REQ;
         cand_idx = IW'(cand);
         if (!found && req_i[cand_idx]) begin
            found             = 1'b1;
            grant_o[cand_idx] = 1'b1;
            idx_o             = cand_idx;
         end
      end
   end

endmodule

// File: rtl/proto_job_scheduler.sv
// Round-robin job scheduler sharing the SPI, I2C and UART engines among NUM_REQ requesters.
// Define SCHED_TIMEOUT_EN to add a watchdog on the engine wait states.
module proto_job_scheduler
   import proto_sched_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [2*NUM_REQ-1:0] req_proto,
   input  logic [7*NUM_REQ-1:0] req_addr,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   done,
   output logic [NUM_REQ-1:0]   err,
   output logic [7:0]           rsp_data,
   output logic [2:0]           eng_select,
   output logic [6:0]           eng_addr,
   output logic [7:0]           eng_data,
   input  logic [2:0]           eng_busy,
   input  logic [2:0]           eng_valid,
   input  logic [7:0]           eng_rx_data,
   output logic                 sched_busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [2:0]         state_q, state_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]      win_q, win_d;
   logic [1:0]         proto_q, proto_d;
   logic [6:0]         addr_q, addr_d;
   logic [7:0]         data_q, data_d;
   logic [7:0]         rsp_q, rsp_d;
   logic [2:0]         sel_q, sel_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic [NUM_REQ-1:0] err_q, err_d;

   logic [NUM_REQ-1:0] arb_grant;
   logic [IW-1:0]      arb_idx;
   logic [NUM_REQ-1:0] win_onehot;
   logic [1:0]         proto_arr [NUM_REQ];
   logic [6:0]         addr_arr  [NUM_REQ];
   logic [7:0]         data_arr  [NUM_REQ];
   logic               busy_sel, valid_sel;

`ifdef SCHED_TIMEOUT_EN
   localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wd_q, wd_d;
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
      .req_i   (req),
      .ptr_i   (rr_ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx)
   );

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign proto_arr[g] = req_proto[2*g +: 2];
      assign addr_arr[g]  = req_addr[7*g +: 7];
      assign data_arr[g]  = req_data[8*g +: 8];
   end

   // Only the flags of the engine we selected matter; the others are masked off.
   assign busy_sel  = |(eng_busy & sel_q);
   assign valid_sel = |(eng_valid & sel_q);

   always_comb begin
      win_onehot        = '0;
      win_onehot[win_q] = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      win_d    = win_q;
      proto_d  = proto_q;
      addr_d   = addr_q;
      data_d   = data_q;
      rsp_d    = rsp_q;
      sel_d    = sel_q;
      gnt_d    = '0;
      done_d   = '0;
      err_d    = '0;
`ifdef SCHED_TIMEOUT_EN
      wd_d     = wd_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               gnt_d    = arb_grant;
               win_d    = arb_idx;
               proto_d  = proto_arr[arb_idx];
               addr_d   = addr_arr[arb_idx];
               data_d   = data_arr[arb_idx];
               rr_ptr_d = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
               if (proto_arr[arb_idx] == PROTO_ILL) begin
                  err_d   = arb_grant;
                  state_d = ST_RESP_ERR;
               end else begin
                  state_d = ST_LAUNCH;
               end
            end
         end
         ST_LAUNCH: begin
            sel_d   = proto_onehot(proto_q);
            state_d = ST_WAIT_BUSY;
`ifdef SCHED_TIMEOUT_EN
            wd_d    = '0;
`endif
         end
         // A valid pulse ends the job from either wait state; completion beats the watchdog.
         ST_WAIT_BUSY, ST_WAIT_DONE: begin
            if (valid_sel || (state_q == ST_WAIT_DONE && !busy_sel)) begin
               state_d = ST_RESP;
            end
`ifdef SCHED_TIMEOUT_EN
            else if (wd_q == WD_LIMIT) begin
               err_d   = win_onehot;
               sel_d   = '0;
               state_d = ST_IDLE;
            end
`endif
            else if (state_q == ST_WAIT_BUSY && busy_sel) begin
               state_d = ST_WAIT_DONE;
            end
`ifdef SCHED_TIMEOUT_EN
            wd_d = wd_q + 16'd1;
`endif
         end
         ST_RESP: begin
            done_d  = win_onehot;
            rsp_d   = eng_rx_data;
            sel_d   = '0;
            state_d = ST_IDLE;
         end
         ST_RESP_ERR: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         win_q    <= '0;
         proto_q  <= PROTO_SPI;
         addr_q   <= '0;
         data_q   <= '0;
         rsp_q    <= '0;
         sel_q    <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         err_q    <= '0;
`ifdef SCHED_TIMEOUT_EN
         wd_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         win_q    <= win_d;
         proto_q  <= proto_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         rsp_q    <= rsp_d;
         sel_q    <= sel_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
`ifdef SCHED_TIMEOUT_EN
         wd_q     <= wd_d;
`endif
      end
   end

   assign gnt        = gnt_q;
   assign done       = done_q;
   assign err        = err_q;
   assign rsp_data   = rsp_q;
   assign eng_select = sel_q;
   assign eng_addr   = addr_q;
   assign eng_data   = data_q;
   assign sched_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_proto_job_scheduler.sv
// Self-checking bench for proto_job_scheduler: randomized jobs against a round-robin
// reference model plus directed single, contention, illegal, I2C, reset and timeout scenarios.
module tb_proto_job_scheduler;

   localparam int N = 4;
`ifdef SCHED_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 4096;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [2*N-1:0] req_proto;
   logic [7*N-1:0] req_addr;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   gnt, done, err;
   logic [7:0]     rsp_data;
   logic [2:0]     eng_select;
   logic [6:0]     eng_addr;
   logic [7:0]     eng_data;
   logic [2:0]     eng_busy, eng_valid;
   logic [7:0]     eng_rx_data;
   logic           sched_busy;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference state: round-robin pointer, last good rx byte, per-requester payloads.
   int         rrPtr;
   logic [7:0] lastRsp;
   logic [1:0] rqProto [N];
   logic [6:0] rqAddr  [N];
   logic [7:0] rqData  [N];

   proto_job_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_proto   (req_proto),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .gnt         (gnt),
      .done        (done),
      .err         (err),
      .rsp_data    (rsp_data),
      .eng_select  (eng_select),
      .eng_addr    (eng_addr),
      .eng_data    (eng_data),
      .eng_busy    (eng_busy),
      .eng_valid   (eng_valid),
      .eng_rx_data (eng_rx_data),
      .sched_busy  (sched_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "[TB] global timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int pickWinner(logic [N-1:0] r, int p);
      int k;
      for (int i = 0; i < N; i++) begin
         k = (p + i) % N;
         if (r[k[1:0]]) return k;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] ohOf(int k);
      logic [N-1:0] v;
      v = '0;
      v[k[1:0]] = 1'b1;
      return v;
   endfunction

   function automatic logic [2:0] engineFor(logic [1:0] pr);
      case (pr)
         2'b00:   return 3'b001;
         2'b01:   return 3'b010;
         2'b10:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] noise(logic [2:0] sel);
      return 3'($urandom) & ~sel;
   endfunction

   task automatic drivePayload();
      for (int i = 0; i < N; i++) begin
         req_proto[2*i +: 2] = rqProto[i[1:0]];
         req_addr[7*i +: 7]  = rqAddr[i[1:0]];
         req_data[8*i +: 8]  = rqData[i[1:0]];
      end
   endtask

   task automatic applyReset();
      reset       = 1'b1;
      req         = '0;
      eng_busy    = '0;
      eng_valid   = '0;
      eng_rx_data = '0;
      step();
      step();
      reset   = 1'b0;
      rrPtr   = 0;
      lastRsp = 8'h00;
   endtask

   // Runs one arbitration round and, for a legal job, plays the engine.
   // mode 0: busy for len cycles then drop; mode 1: len idle cycles then a valid pulse.
   task automatic serveJob(input logic [N-1:0] pattern, input bit keep, input int mode,
                           input int len, input int rxIn, output int w,
                           output logic [2:0] selSeen, output logic [N-1:0] gntSeen,
                           output int gntLat);
      logic [N-1:0] expOh;
      logic [2:0]   sel;
      logic [7:0]   rx;
      int           wi, m, l;
      bit           got, stray;
      req     = pattern;
      wi      = pickWinner(req, rrPtr);
      selSeen = 3'b000;
      gntSeen = '0;
      gntLat  = 0;
      got     = 1'b0;
      w       = -1;
      for (int i = 0; i < 6 && !got; i++) begin
         step();
         gntLat++;
         if (gnt != '0) got = 1'b1;
      end
      gntSeen = gnt;
      testsRun++;
      if (!got || wi < 0) begin
         testsFailed++;
         $display("[TB] FAIL gnt_wait: got gnt=%b, required a grant for req=%b", gnt, pattern);
         return;
      end
      w     = wi;
      expOh = ohOf(wi);
      if (gnt !== expOh) begin
         testsFailed++;
         $display("[TB] FAIL grant: got %b, required %b (ptr %0d)", gnt, expOh, rrPtr);
      end
      rrPtr = (wi + 1) % N;
      if (!keep) req[wi[1:0]] = 1'b0;

      if (rqProto[wi[1:0]] == 2'b11) begin
         testsRun++;
         if (err !== expOh || done !== '0) begin
            testsFailed++;
            $display("[TB] FAIL illegal_err: got err=%b done=%b, required err=%b done=0", err, done, expOh);
         end
         step();
         testsRun++;
         if (eng_select !== 3'b000 || err !== '0 || done !== '0 || sched_busy !== 1'b0 || rsp_data !== lastRsp) begin
            testsFailed++;
            $display("[TB] FAIL illegal_after: got sel=%b err=%b done=%b busy=%b rsp=%h, required 000/0/0/0/%h",
                     eng_select, err, done, sched_busy, rsp_data, lastRsp);
         end
         return;
      end

      testsRun++;
      if (err !== '0) begin
         testsFailed++;
         $display("[TB] FAIL legal_err: got err=%b, required 0", err);
      end
      sel   = engineFor(rqProto[wi[1:0]]);
      stray = 1'b0;
      eng_rx_data = 8'($urandom);
      step();
      selSeen = eng_select;
      testsRun++;
      if (eng_select !== sel) begin
         testsFailed++;
         $display("[TB] FAIL select: got %b, required %b", eng_select, sel);
      end
      testsRun++;
      if (eng_data !== rqData[wi[1:0]] || eng_addr !== rqAddr[wi[1:0]]) begin
         testsFailed++;
         $display("[TB] FAIL payload: got addr=%h data=%h, required addr=%h data=%h",
                  eng_addr, eng_data, rqAddr[wi[1:0]], rqData[wi[1:0]]);
      end

      m  = (mode < 0) ? int'($urandom_range(0, 1)) : mode;
      l  = (len < 0) ? int'($urandom_range(1, 4)) : len;
      rx = (rxIn < 0) ? 8'($urandom) : 8'(rxIn);
      if (m == 0) begin
         eng_rx_data = rx;
         for (int i = 0; i < l; i++) begin
            eng_busy  = sel | noise(sel);
            eng_valid = noise(sel);
            step();
            if (gnt != '0) stray = 1'b1;
         end
         eng_busy  = noise(sel);
         eng_valid = noise(sel);
      end else begin
         for (int i = 0; i < l; i++) begin
            eng_busy  = noise(sel);
            eng_valid = noise(sel);
            step();
            if (gnt != '0) stray = 1'b1;
         end
         eng_busy    = noise(sel);
         eng_valid   = sel | noise(sel);
         eng_rx_data = rx;
      end
      step();
      if (gnt != '0) stray = 1'b1;
      testsRun++;
      if (done !== '0) begin
         testsFailed++;
         $display("[TB] FAIL early_done: got %b, required 0", done);
      end
      eng_busy  = noise(sel);
      eng_valid = noise(sel);
      step();
      testsRun++;
      if (done !== expOh) begin
         testsFailed++;
         $display("[TB] FAIL done: got %b, required %b", done, expOh);
      end
      testsRun++;
      if (rsp_data !== rx) begin
         testsFailed++;
         $display("[TB] FAIL rsp_data: got %h, required %h", rsp_data, rx);
      end
      testsRun++;
      if (eng_select !== 3'b000 || sched_busy !== 1'b0 || err !== '0 || gnt !== '0) begin
         testsFailed++;
         $display("[TB] FAIL release: got sel=%b busy=%b err=%b gnt=%b, required all 0",
                  eng_select, sched_busy, err, gnt);
      end
      lastRsp   = rx;
      eng_busy  = '0;
      eng_valid = '0;
      testsRun++;
      if (stray) begin
         testsFailed++;
         $display("[TB] FAIL stray_grant: got a grant during the job, required none");
      end
   endtask

   task automatic checkResetValues(input string tag);
      testsRun++;
      if (gnt !== '0 || done !== '0 || err !== '0 || eng_select !== 3'b000 || eng_addr !== 7'h00 ||
          eng_data !== 8'h00 || rsp_data !== 8'h00 || sched_busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL %s: got gnt=%b done=%b err=%b sel=%b addr=%h data=%h rsp=%h busy=%b, required all 0",
                  tag, gnt, done, err, eng_select, eng_addr, eng_data, rsp_data, sched_busy);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) begin
         rqProto[i[1:0]] = 2'b00;
         rqAddr[i[1:0]]  = 7'h00;
         rqData[i[1:0]]  = 8'h00;
      end
      drivePayload();
      applyReset();
      checkResetValues("reset_state");
   endtask

   task automatic test_single();
      int w, lat;
      logic [2:0] s;
      logic [N-1:0] g;
      rqProto[0] = 2'b00;
      rqAddr[0]  = 7'h12;
      rqData[0]  = 8'hA5;
      drivePayload();
      serveJob(4'b0001, 1'b0, 0, 10, 8'h3C, w, s, g, lat);
      testsRun++;
      if (lat != 1 || g !== 4'b0001 || s !== 3'b001 || rsp_data !== 8'h3C) begin
         testsFailed++;
         $display("[TB] FAIL single_job: got lat=%0d gnt=%b sel=%b rsp=%h, required 1/0001/001/3c", lat, g, s, rsp_data);
      end
   endtask

   task automatic test_contention();
      int w, lat;
      logic [2:0] s;
      logic [N-1:0] g;
      int order [5] = '{0, 1, 2, 3, 0};
      applyReset();
      for (int i = 0; i < N; i++) begin
         rqProto[i[1:0]] = 2'($urandom_range(0, 2));
         rqAddr[i[1:0]]  = 7'($urandom);
         rqData[i[1:0]]  = 8'($urandom);
      end
      drivePayload();
      for (int i = 0; i < 5; i++) begin
         serveJob(4'b1111, 1'b1, -1, -1, -1, w, s, g, lat);
         testsRun++;
         if (g !== ohOf(order[i])) begin
            testsFailed++;
            $display("[TB] FAIL contention_order: job %0d got gnt=%b, required %b", i, g, ohOf(order[i]));
         end
      end
      req = '0;
   endtask

   task automatic test_illegal();
      int w, lat;
      logic [2:0] s;
      logic [N-1:0] g;
      rqProto[2] = 2'b11;
      rqAddr[2]  = 7'h33;
      rqData[2]  = 8'h44;
      drivePayload();
      serveJob(4'b0100, 1'b0, -1, -1, -1, w, s, g, lat);
      testsRun++;
      if (g !== 4'b0100) begin
         testsFailed++;
         $display("[TB] FAIL illegal_gnt: got %b, required 0100", g);
      end
   endtask

   task automatic test_i2c();
      int w, lat;
      logic [2:0] s;
      logic [N-1:0] g;
      rqProto[1] = 2'b01;
      rqAddr[1]  = 7'h50;
      rqData[1]  = 8'h11;
      drivePayload();
      serveJob(4'b0010, 1'b0, 1, 2, -1, w, s, g, lat);
      testsRun++;
      if (s !== 3'b010 || eng_addr !== 7'h50 || eng_data !== 8'h11) begin
         testsFailed++;
         $display("[TB] FAIL i2c_job: got sel=%b addr=%h data=%h, required 010/50/11", s, eng_addr, eng_data);
      end
   endtask

   task automatic test_random();
      int w, lat, k;
      logic [2:0] s;
      logic [N-1:0] g;
      applyReset();
      req = '0;
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i[1:0]] && $urandom_range(0, 2) == 0) begin
               rqProto[i[1:0]] = 2'($urandom);
               rqAddr[i[1:0]]  = 7'($urandom);
               rqData[i[1:0]]  = 8'($urandom);
               req[i[1:0]]     = 1'b1;
            end
         end
         if (req == '0) begin
            k = int'($urandom_range(0, N - 1));
            rqProto[k[1:0]] = 2'($urandom);
            rqAddr[k[1:0]]  = 7'($urandom);
            rqData[k[1:0]]  = 8'($urandom);
            req[k[1:0]]     = 1'b1;
         end
         drivePayload();
         serveJob(req, 1'b0, -1, -1, -1, w, s, g, lat);
         if (w >= 0 && $urandom_range(0, 1) == 1) req[w[1:0]] = 1'b1;
      end
      req = '0;
      step();
   endtask

   task automatic test_reset_midjob();
      int w, lat;
      logic [2:0] s;
      logic [N-1:0] g;
      applyReset();
      rqProto[0] = 2'b00;
      rqAddr[0]  = 7'h2A;
      rqData[0]  = 8'h77;
      rqProto[1] = 2'b10;
      rqAddr[1]  = 7'h15;
      rqData[1]  = 8'h99;
      drivePayload();
      req = 4'b0001;
      step();
      req = '0;
      step();
      eng_busy = 3'b001;
      step();
      step();
      reset = 1'b1;
      step();
      checkResetValues("reset_midjob");
      reset    = 1'b0;
      eng_busy = '0;
      rrPtr    = 0;
      lastRsp  = 8'h00;
      serveJob(4'b0011, 1'b0, 0, 1, -1, w, s, g, lat);
      testsRun++;
      if (g !== 4'b0001) begin
         testsFailed++;
         $display("[TB] FAIL ptr_after_reset: got gnt=%b, required 0001", g);
      end
   endtask

`ifdef SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int w, lat, cnt;
      logic [2:0] s;
      logic [N-1:0] g;
      logic [7:0] rspBefore;
      applyReset();
      rqProto[3] = 2'b00;
      rqAddr[3]  = 7'h01;
      rqData[3]  = 8'h5A;
      drivePayload();
      rspBefore = rsp_data;
      req = 4'b1000;
      step();
      req = '0;
      rrPtr = 0;
      step();
      eng_busy = 3'b001;
      cnt = 0;
      while (err == '0 && cnt < 40) begin
         step();
         cnt++;
      end
      testsRun++;
      if (cnt != TO || err !== 4'b1000) begin
         testsFailed++;
         $display("[TB] FAIL timeout_err: got err=%b after %0d cycles, required 1000 after %0d", err, cnt, TO);
      end
      testsRun++;
      if (eng_select !== 3'b000 || done !== '0 || rsp_data !== rspBefore) begin
         testsFailed++;
         $display("[TB] FAIL timeout_release: got sel=%b done=%b rsp=%h, required 000/0/%h",
                  eng_select, done, rsp_data, rspBefore);
      end
      eng_busy = '0;
      rqProto[1] = 2'b01;
      rqAddr[1]  = 7'h22;
      rqData[1]  = 8'h33;
      drivePayload();
      serveJob(4'b0010, 1'b0, 0, 2, -1, w, s, g, lat);
   endtask
`endif

   initial begin
      req         = '0;
      req_proto   = '0;
      req_addr    = '0;
      req_data    = '0;
      eng_busy    = '0;
      eng_valid   = '0;
      eng_rx_data = '0;
      reset       = 1'b1;
      test_reset();
      test_single();
      test_illegal();
      test_i2c();
      test_contention();
      test_random();
      test_reset_midjob();
`ifdef SCHED_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
